// File: rtl/rr_pick.sv
// rr_pick: combinational grant decision for the two-requester lane.
// Chooses the next lane owner and whether a new tenure begins.
module rr_pick #(
  parameter int BURST = 4
) (
  input  logic [1:0] state,
  input  logic [3:0] cnt,
  input  logic       last2,
  input  logic       free,
  input  logic       req1,
  input  logic       req2,
  output logic       gnt1,
  output logic       gnt2,
  output logic [1:0] nxt_state,
  output logic       restart
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN1 = 2'd1;
  localparam logic [1:0] OWN2 = 2'd2;
  localparam logic [3:0] CAP  = 4'(BURST);

  logic at_cap;

  assign at_cap = (cnt == CAP);

  // grant selection and next tenure state
  always_comb begin
    gnt1      = 1'b0;
    gnt2      = 1'b0;
    nxt_state = state;
    restart   = 1'b0;
    if (free) begin
      case (state)
        IDLE: begin
          restart = 1'b1;
          if (last2) begin
            if (req1) begin
              gnt1      = 1'b1;
              nxt_state = OWN1;
            end else if (req2) begin
              gnt2      = 1'b1;
              nxt_state = OWN2;
            end
          end else begin
            if (req2) begin
              gnt2      = 1'b1;
              nxt_state = OWN2;
            end else if (req1) begin
              gnt1      = 1'b1;
              nxt_state = OWN1;
            end
          end
        end
        OWN1: begin
          if (req1 && !(at_cap && req2)) begin
            gnt1    = 1'b1;
            restart = at_cap;
          end else if (req2) begin
            gnt2      = 1'b1;
            nxt_state = OWN2;
            restart   = 1'b1;
          end else begin
            nxt_state = IDLE;
          end
        end
        OWN2: begin
          if (req2 && !(at_cap && req1)) begin
            gnt2    = 1'b1;
            restart = at_cap;
          end else if (req1) begin
            gnt1      = 1'b1;
            nxt_state = OWN1;
            restart   = 1'b1;
          end else begin
            nxt_state = IDLE;
          end
        end
        default: begin
          nxt_state = IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/rr_lane_arbiter.sv
// rr_lane_arbiter: two requesters share one registered output lane.
// Round-robin tenures of up to BURST words when both are waiting.
module rr_lane_arbiter #(
  parameter int WIDTH1    = 2,
  parameter int WIDTH2    = 4,
  parameter int OUT_WIDTH = 4,
  parameter int BURST     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req1,
  input  logic [WIDTH1-1:0]    data1,
  input  logic                 req2,
  input  logic [WIDTH2-1:0]    data2,
  input  logic                 out_ready,
  output logic                 gnt1,
  output logic                 gnt2,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_src
);

  localparam logic [1:0] IDLE = 2'd0;

  logic [1:0] state;
  logic [1:0] nxt_state;
  logic [3:0] cnt;
  logic       last2;
  logic       free;
  logic       p_gnt1;
  logic       p_gnt2;
  logic       restart;

  assign free = !out_valid || out_ready;

  rr_pick #(
    .BURST(BURST)
  ) u_pick (
    .state    (state),
    .cnt      (cnt),
    .last2    (last2),
    .free     (free),
    .req1     (req1),
    .req2     (req2),
    .gnt1     (p_gnt1),
    .gnt2     (p_gnt2),
    .nxt_state(nxt_state),
    .restart  (restart)
  );

  assign gnt1 = p_gnt1 && !reset;
  assign gnt2 = p_gnt2 && !reset;

  // tenure state, grant counter and last owner; frozen while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      last2 <= 1'b1;
    end else if (free) begin
      state <= nxt_state;
      if (nxt_state == IDLE) begin
        cnt <= 4'd0;
      end else if (restart) begin
        cnt <= 4'd1;
      end else begin
        cnt <= cnt + 4'd1;
      end
      if (gnt1) begin
        last2 <= 1'b0;
      end else if (gnt2) begin
        last2 <= 1'b1;
      end
    end
  end

  // output lane register: load on grant, drain when free and idle
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else if (gnt1) begin
      out_valid <= 1'b1;
      out_data  <= OUT_WIDTH'(data1);
      out_src   <= 1'b0;
    end else if (gnt2) begin
      out_valid <= 1'b1;
      out_data  <= OUT_WIDTH'(data2);
      out_src   <= 1'b1;
    end else if (free) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_lane_arbiter.sv
// tb_rr_lane_arbiter: directed scenarios plus randomized traffic
// checked against a tenure-level reference model.
module tb_rr_lane_arbiter;

  localparam int BURST = 4;

  logic       clk;
  logic       reset;
  logic       req1;
  logic [1:0] data1;
  logic       req2;
  logic [3:0] data2;
  logic       out_ready;
  logic       gnt1;
  logic       gnt2;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_src;

  logic       w_reset;
  logic       w_req1;
  logic [2:0] w_data1;
  logic       w_req2;
  logic [3:0] w_data2;
  logic       w_ready;
  logic       w_gnt1;
  logic       w_gnt2;
  logic       w_valid;
  logic [7:0] w_data;
  logic       w_src;

  int passed;
  int total;

  int         m_owner;
  int         m_cnt;
  int         m_last;
  bit         m_valid;
  logic [3:0] m_data;
  bit         m_src;
  int         eg;

  rr_lane_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req1     (req1),
    .data1    (data1),
    .req2     (req2),
    .data2    (data2),
    .out_ready(out_ready),
    .gnt1     (gnt1),
    .gnt2     (gnt2),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src)
  );

  rr_lane_arbiter #(
    .WIDTH1   (3),
    .WIDTH2   (4),
    .OUT_WIDTH(8)
  ) dut_w (
    .clk      (clk),
    .reset    (w_reset),
    .req1     (w_req1),
    .data1    (w_data1),
    .req2     (w_req2),
    .data2    (w_data2),
    .out_ready(w_ready),
    .gnt1     (w_gnt1),
    .gnt2     (w_gnt2),
    .out_valid(w_valid),
    .out_data (w_data),
    .out_src  (w_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit rq(input int n);
    return (n == 1) ? req1 : req2;
  endfunction

  // who should be granted right now, from the arbitration rules
  task automatic model_pick();
    int g;
    int pref;
    int oth;
    bit yield;
    g = 0;
    if (!reset && (!m_valid || out_ready)) begin
      if (m_owner == 0) begin
        pref = (m_last == 2) ? 1 : 2;
        if (rq(pref)) g = pref;
        else if (rq(3 - pref)) g = 3 - pref;
      end else begin
        oth = 3 - m_owner;
        yield = (m_cnt == BURST) && rq(oth);
        if (rq(m_owner) && !yield) g = m_owner;
        else if (rq(oth)) g = oth;
      end
    end
    eg = g;
  endtask

  task automatic model_update();
    if (reset) begin
      m_owner = 0;
      m_cnt   = 0;
      m_last  = 2;
      m_valid = 0;
      m_data  = 4'h0;
      m_src   = 0;
    end else if (eg != 0) begin
      if (eg == m_owner) begin
        m_cnt = (m_cnt == BURST) ? 1 : m_cnt + 1;
      end else begin
        m_owner = eg;
        m_cnt   = 1;
      end
      m_last  = eg;
      m_valid = 1;
      m_data  = (eg == 1) ? {2'b00, data1} : data2;
      m_src   = (eg == 2);
    end else if (!m_valid || out_ready) begin
      m_owner = 0;
      m_cnt   = 0;
      m_valid = 0;
    end
  endtask

  task automatic apply(input bit r1, input logic [1:0] d1,
                       input bit r2, input logic [3:0] d2,
                       input bit rdy, input bit rst);
    req1      = r1;
    data1     = d1;
    req2      = r2;
    data2     = d2;
    out_ready = rdy;
    reset     = rst;
    #1;
    model_pick();
  endtask

  task automatic tick();
    model_pick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    apply(0, 2'd0, 0, 4'd0, 1, 1);
    tick();
  endtask

  task automatic test_reset();
    apply(1, 2'd3, 1, 4'hF, 1, 1);
    total++;
    if ({gnt1, gnt2} !== 2'b00)
      $display("FAIL reset_gnt: got %b expected 00", {gnt1, gnt2});
    else passed++;
    tick();
    total++;
    if ({out_valid, out_data, out_src} !== 6'b0)
      $display("FAIL reset_out: got v=%b d=%h s=%b expected 0/0/0",
               out_valid, out_data, out_src);
    else passed++;
  endtask

  task automatic test_fair_burst();
    bit exp_src [9];
    exp_src = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply(1, 2'b11, 1, 4'hA, 1, 0);
      total++;
      if ({gnt1, gnt2} !== {~exp_src[i], exp_src[i]})
        $display("FAIL burst_gnt[%0d]: got %b expected %b", i,
                 {gnt1, gnt2}, {~exp_src[i], exp_src[i]});
      else passed++;
      tick();
      total++;
      if (out_src !== exp_src[i] ||
          out_data !== (exp_src[i] ? 4'hA : 4'h3) || out_valid !== 1'b1)
        $display("FAIL burst_word[%0d]: got s=%b d=%h v=%b expected s=%b",
                 i, out_src, out_data, out_valid, exp_src[i]);
      else passed++;
    end
  endtask

  task automatic test_single_stream();
    logic [1:0] d;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      d = 2'(i);
      apply(1, d, 0, 4'h0, 1, 0);
      total++;
      if (gnt1 !== 1'b1 || gnt2 !== 1'b0)
        $display("FAIL stream_gnt[%0d]: got %b%b expected 10", i, gnt1, gnt2);
      else passed++;
      if (i == 0) begin
        total++;
        if (out_valid !== 1'b0)
          $display("FAIL stream_v0: got %b expected 0", out_valid);
        else passed++;
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== {2'b00, d})
        $display("FAIL stream_word[%0d]: got v=%b d=%h expected 1/%h",
                 i, out_valid, out_data, {2'b00, d});
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    apply(0, 2'd0, 1, 4'h5, 1, 0);
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'h5)
      $display("FAIL bp_load: got v=%b d=%h expected 1/5", out_valid, out_data);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      apply(1, 2'b10, 1, 4'h9, 0, 0);
      total++;
      if ({gnt1, gnt2} !== 2'b00)
        $display("FAIL bp_gnt[%0d]: got %b expected 00", i, {gnt1, gnt2});
      else passed++;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 4'h5 || out_src !== 1'b1)
        $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%b expected 1/5/1",
                 i, out_valid, out_data, out_src);
      else passed++;
    end
    apply(1, 2'b10, 1, 4'h9, 1, 0);
    total++;
    if ({gnt1, gnt2} !== 2'b01)
      $display("FAIL bp_release_gnt: got %b expected 01", {gnt1, gnt2});
    else passed++;
    tick();
    total++;
    if (out_data !== 4'h9)
      $display("FAIL bp_release_word: got %h expected 9", out_data);
    else passed++;
  endtask

  task automatic test_handoff();
    do_reset();
    apply(1, 2'd1, 0, 4'h0, 1, 0);
    tick();
    tick();
    apply(0, 2'd1, 1, 4'hC, 1, 0);
    total++;
    if ({gnt1, gnt2} !== 2'b01)
      $display("FAIL handoff_gnt: got %b expected 01", {gnt1, gnt2});
    else passed++;
    tick();
    total++;
    if (out_src !== 1'b1 || out_data !== 4'hC)
      $display("FAIL handoff_word: got s=%b d=%h expected 1/C",
               out_src, out_data);
    else passed++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    apply(1, 2'd3, 1, 4'hA, 1, 0);
    tick();
    tick();
    apply(1, 2'd3, 1, 4'hA, 1, 1);
    total++;
    if ({gnt1, gnt2} !== 2'b00)
      $display("FAIL midrst_gnt: got %b expected 00", {gnt1, gnt2});
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_data !== 4'h0)
      $display("FAIL midrst_out: got v=%b d=%h expected 0/0",
               out_valid, out_data);
    else passed++;
    apply(1, 2'd3, 1, 4'hA, 1, 0);
    total++;
    if ({gnt1, gnt2} !== 2'b10)
      $display("FAIL midrst_first: got %b expected 10", {gnt1, gnt2});
    else passed++;
    tick();
  endtask

  task automatic test_wide();
    w_reset = 1'b1;
    tick();
    w_reset = 1'b0;
    w_req1  = 1'b1;
    w_data1 = 3'b101;
    w_ready = 1'b1;
    #1;
    total++;
    if (w_gnt1 !== 1'b1)
      $display("FAIL wide_gnt: got %b expected 1", w_gnt1);
    else passed++;
    tick();
    total++;
    if (w_data !== 8'h05 || w_valid !== 1'b1 || w_src !== 1'b0)
      $display("FAIL wide_word: got d=%h v=%b s=%b expected 05/1/0",
               w_data, w_valid, w_src);
    else passed++;
    w_req1 = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 3) != 0, 2'($urandom),
            $urandom_range(0, 2) != 0, 4'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      total++;
      if (gnt1 !== (eg == 1) || gnt2 !== (eg == 2))
        $display("FAIL rand_gnt[%0d]: got %b%b expected grant to %0d",
                 i, gnt1, gnt2, eg);
      else passed++;
      tick();
      total++;
      if (out_valid !== m_valid || out_data !== m_data || out_src !== m_src)
        $display("FAIL rand_out[%0d]: got v=%b d=%h s=%b expected %b/%h/%b",
                 i, out_valid, out_data, out_src, m_valid, m_data, m_src);
      else passed++;
    end
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    m_owner   = 0;
    m_cnt     = 0;
    m_last    = 2;
    m_valid   = 0;
    m_data    = 4'h0;
    m_src     = 0;
    eg        = 0;
    reset     = 1'b1;
    req1      = 1'b0;
    data1     = 2'd0;
    req2      = 1'b0;
    data2     = 4'd0;
    out_ready = 1'b1;
    w_reset   = 1'b1;
    w_req1    = 1'b0;
    w_data1   = 3'd0;
    w_req2    = 1'b0;
    w_data2   = 4'd0;
    w_ready   = 1'b1;
    #2;
    test_reset();
    test_fair_burst();
    test_single_stream();
    test_backpressure();
    test_handoff();
    test_reset_midflight();
    test_wide();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
